// File: rtl/dat_wait_ctrl_pkg.sv
// Shared types and widths for the SD data-line wait controller and its timeout timer.
package dat_wait_pkg;

  localparam int BlockCountWidth   = 16;
  localparam int TimeoutBitsWidth  = 4;
  localparam int TimeoutCountWidth = 29;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_BLOCK  = 2'd2,
    BUSY_WAIT = 2'd3
  } dat_wait_state_e;

  // A requested count of zero still transfers one block.
  function automatic logic [BlockCountWidth-1:0] initial_blocks(
    input logic [BlockCountWidth-1:0] count
  );
    return (count == '0) ? BlockCountWidth'(1) : count;
  endfunction

  function automatic logic [TimeoutCountWidth-1:0] timeout_limit(
    input logic [TimeoutBitsWidth-1:0] bits
  );
    return TimeoutCountWidth'(1) << ({1'b0, bits} + 5'd13);
  endfunction

endpackage

// File: rtl/dat_wait_ctrl_if.sv
// Request/status bundle between transfer control, the DAT receiver and the wait controller.
interface dat_wait_ctrl_if;

  logic                                     start_read_i;
  logic                                     start_busy_i;
  logic [dat_wait_pkg::BlockCountWidth-1:0]  block_count_i;
  logic [dat_wait_pkg::TimeoutBitsWidth-1:0] timeout_bits_i;
  logic                                     abort_i;
  logic                                     block_begin_i;
  logic                                     block_done_i;
  logic                                     dat0_i;
  logic                                     busy_o;
  logic [dat_wait_pkg::BlockCountWidth-1:0]  blocks_left_o;
  logic                                     xfer_done_o;
  logic                                     timeout_err_o;

  modport master (
    output start_read_i, start_busy_i, block_count_i, timeout_bits_i,
           abort_i, block_begin_i, block_done_i, dat0_i,
    input  busy_o, blocks_left_o, xfer_done_o, timeout_err_o
  );

  modport slave (
    input  start_read_i, start_busy_i, block_count_i, timeout_bits_i,
           abort_i, block_begin_i, block_done_i, dat0_i,
    output busy_o, blocks_left_o, xfer_done_o, timeout_err_o
  );

endinterface

// File: rtl/dat_wait_ctrl_timeout.sv
// Data-line timeout timer: counts divided ticks while running and flags 2^(bits+13) ticks.
module dat_timeout
  import dat_wait_pkg::*;
#(
  parameter int ClockDiv = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        running_i,
  input  logic [TimeoutBitsWidth-1:0] timeout_bits_i,
  output logic                        timeout_o
);

  localparam int                  DivWidth = (ClockDiv > 1) ? $clog2(ClockDiv) : 1;
  localparam logic [DivWidth-1:0] DivLast  = DivWidth'(ClockDiv - 1);

  logic [DivWidth-1:0]          div_q;
  logic [TimeoutCountWidth-1:0] count_q;
  logic                         tick;

  assign tick      = (div_q == DivLast);
  assign timeout_o = running_i && (count_q >= timeout_limit(timeout_bits_i));

  // Dropping running_i clears both stages so every wait phase starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      count_q <= '0;
    end else if (!running_i) begin
      div_q   <= '0;
      count_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick && !timeout_o) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dat_wait_ctrl.sv
// Sequences read-access and busy waits on the SD data lines and reports
// completion, data timeout and the remaining block count.
module dat_wait_ctrl
  import dat_wait_pkg::*;
#(
  parameter int ClockDiv = 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  dat_wait_ctrl_if.slave bus
);

  dat_wait_state_e              state_q, state_d, prev_q;
  logic [BlockCountWidth-1:0]   blocks_q, blocks_d;
  logic                         xfer_q, xfer_d;
  logic                         terr_q, terr_d;
  logic                         first_cycle;
  logic                         running;
  logic                         timeout;

  dat_timeout #(
    .ClockDiv(ClockDiv)
  ) u_timeout (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .running_i      (running),
    .timeout_bits_i (bus.timeout_bits_i),
    .timeout_o      (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      prev_q   <= IDLE;
      blocks_q <= '0;
      xfer_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= state_q;
      blocks_q <= blocks_d;
      xfer_q   <= xfer_d;
      terr_q   <= terr_d;
    end
  end

  // Card events outrank a coincident timeout; abort outranks everything.
  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    xfer_d   = 1'b0;
    terr_d   = 1'b0;
    if (bus.abort_i) begin
      state_d  = IDLE;
      blocks_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_read_i) begin
            state_d  = RD_WAIT;
            blocks_d = initial_blocks(bus.block_count_i);
          end else if (bus.start_busy_i) begin
            state_d = BUSY_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.block_begin_i) begin
            state_d = RD_BLOCK;
          end else if (timeout) begin
            state_d = IDLE;
            terr_d  = 1'b1;
          end
        end
        RD_BLOCK: begin
          if (bus.block_done_i) begin
            if (blocks_q <= BlockCountWidth'(1)) begin
              state_d  = IDLE;
              blocks_d = '0;
              xfer_d   = 1'b1;
            end else begin
              state_d  = RD_WAIT;
              blocks_d = blocks_q - 1'b1;
            end
          end
        end
        BUSY_WAIT: begin
          if (!first_cycle && bus.dat0_i) begin
            state_d = IDLE;
            xfer_d  = 1'b1;
          end else if (timeout) begin
            state_d = IDLE;
            terr_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The entry cycle of a wait phase keeps the timer cleared and masks DAT0.
  always_comb begin
    first_cycle       = (state_q != prev_q);
    running           = ((state_q == RD_WAIT) || (state_q == BUSY_WAIT)) && !first_cycle;
    bus.busy_o        = (state_q != IDLE);
    bus.blocks_left_o = blocks_q;
    bus.xfer_done_o   = xfer_q;
    bus.timeout_err_o = terr_q;
  end

endmodule

// File: tb/tb_dat_wait_ctrl.sv
// Self-checking bench for dat_wait_ctrl: vector table, directed corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_dat_wait_ctrl;
  import dat_wait_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dat_wait_ctrl_if bus();

  dat_wait_ctrl #(
    .ClockDiv(1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        start_read;
    logic        start_busy;
    logic [15:0] count;
    logic        abort;
    logic        blk_begin;
    logic        blk_done;
    logic        dat0;
    logic        exp_busy;
    logic [15:0] exp_blocks;
    logic        exp_xfer;
    logic        exp_terr;
  } vec_t;

  int checks   = 0;
  int errors   = 0;
  int xfer_cnt = 0;
  int terr_cnt = 0;

  vec_t vecs[16];

  function automatic vec_t mk(input logic sr, input logic sb, input logic [15:0] cnt,
                              input logic ab, input logic bb, input logic bd, input logic d0,
                              input logic eb, input logic [15:0] ebl, input logic ex,
                              input logic et);
    vec_t v;
    v.start_read = sr;  v.start_busy = sb; v.count = cnt;
    v.abort = ab;       v.blk_begin = bb;  v.blk_done = bd; v.dat0 = d0;
    v.exp_busy = eb;    v.exp_blocks = ebl;
    v.exp_xfer = ex;    v.exp_terr = et;
    return v;
  endfunction

  // One clock step; outputs are sampled on the falling edge and pulses tallied.
  task automatic step();
    @(negedge clk);
    if (bus.xfer_done_o)   xfer_cnt++;
    if (bus.timeout_err_o) terr_cnt++;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start_read_i  = 1'b0;
    bus.start_busy_i  = 1'b0;
    bus.block_count_i = '0;
    bus.abort_i       = 1'b0;
    bus.block_begin_i = 1'b0;
    bus.block_done_i  = 1'b0;
    bus.dat0_i        = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.start_read_i  = v.start_read;
    bus.start_busy_i  = v.start_busy;
    bus.block_count_i = v.count;
    bus.abort_i       = v.abort;
    bus.block_begin_i = v.blk_begin;
    bus.block_done_i  = v.blk_done;
    bus.dat0_i        = v.dat0;
  endtask

  task automatic pulse_read(input logic [15:0] cnt);
    bus.start_read_i  = 1'b1;
    bus.block_count_i = cnt;
    step();
    bus.start_read_i  = 1'b0;
  endtask

  task automatic pulse_busy();
    bus.start_busy_i = 1'b1;
    step();
    bus.start_busy_i = 1'b0;
  endtask

  task automatic pulse_begin();
    bus.block_begin_i = 1'b1;
    step();
    bus.block_begin_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.block_done_i = 1'b1;
    step();
    bus.block_done_i = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
  endtask

  task automatic wait_pulse(input int limit, output int lat, output logic got_x,
                            output logic got_t);
    lat   = 0;
    got_x = 1'b0;
    got_t = 1'b0;
    while (lat < limit && !got_x && !got_t) begin
      step();
      lat++;
      got_x = bus.xfer_done_o;
      got_t = bus.timeout_err_o;
    end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   xs;
    int   ts;
    logic gx;
    logic gt;

    clear_inputs();
    bus.timeout_bits_i = 4'd0;
    rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset busy",   bus.busy_o,        0);
    checkOutput("reset blocks", bus.blocks_left_o, 0);
    checkOutput("reset xfer",   bus.xfer_done_o,   0);
    checkOutput("reset terr",   bus.timeout_err_o, 0);
    rst_n = 1'b1;
    step();

    //                sr sb cnt  ab bb bd d0  busy blk x  t
    vecs[0]  = mk(0, 0, 16'd0, 0, 0, 0, 1,  0, 16'd0, 0, 0);
    vecs[1]  = mk(1, 0, 16'd0, 0, 0, 0, 1,  1, 16'd1, 0, 0);
    vecs[2]  = mk(0, 1, 16'd0, 0, 0, 0, 1,  1, 16'd1, 0, 0);
    vecs[3]  = mk(0, 0, 16'd0, 0, 1, 0, 1,  1, 16'd1, 0, 0);
    vecs[4]  = mk(0, 0, 16'd0, 0, 0, 1, 1,  0, 16'd0, 1, 0);
    vecs[5]  = mk(1, 0, 16'd2, 0, 0, 0, 1,  1, 16'd2, 0, 0);
    vecs[6]  = mk(0, 0, 16'd0, 0, 1, 0, 1,  1, 16'd2, 0, 0);
    vecs[7]  = mk(0, 0, 16'd0, 0, 0, 1, 1,  1, 16'd1, 0, 0);
    vecs[8]  = mk(0, 0, 16'd0, 0, 1, 0, 1,  1, 16'd1, 0, 0);
    vecs[9]  = mk(0, 0, 16'd0, 1, 0, 1, 1,  0, 16'd0, 0, 0);
    vecs[10] = mk(0, 1, 16'd0, 0, 0, 0, 1,  1, 16'd0, 0, 0);
    vecs[11] = mk(0, 0, 16'd0, 0, 0, 0, 1,  1, 16'd0, 0, 0);
    vecs[12] = mk(0, 0, 16'd0, 0, 0, 0, 1,  0, 16'd0, 1, 0);
    vecs[13] = mk(1, 1, 16'd5, 0, 0, 0, 1,  1, 16'd5, 0, 0);
    vecs[14] = mk(0, 0, 16'd0, 1, 0, 0, 1,  0, 16'd0, 0, 0);
    vecs[15] = mk(1, 0, 16'd3, 1, 0, 0, 1,  0, 16'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d busy", i),   bus.busy_o,        vecs[i].exp_busy);
      checkOutput($sformatf("vec%0d blocks", i), bus.blocks_left_o, vecs[i].exp_blocks);
      checkOutput($sformatf("vec%0d xfer", i),   bus.xfer_done_o,   vecs[i].exp_xfer);
      checkOutput($sformatf("vec%0d terr", i),   bus.timeout_err_o, vecs[i].exp_terr);
    end
    clear_inputs();
    step();

    // Single block: start at 0, start bit at +100, block end at +1200.
    xs = xfer_cnt; ts = terr_cnt;
    pulse_read(16'd1);
    checkOutput("single load", bus.blocks_left_o, 1);
    repeat (99) step();
    pulse_begin();
    repeat (1099) step();
    pulse_done();
    checkOutput("single xfer at +1201", bus.xfer_done_o, 1);
    checkOutput("single blocks zero",   bus.blocks_left_o, 0);
    step();
    checkOutput("single xfer one pulse", xfer_cnt - xs, 1);
    checkOutput("single no terr",        terr_cnt - ts, 0);

    // Three blocks with 5000-cycle gaps before each start bit.
    xs = xfer_cnt; ts = terr_cnt;
    pulse_read(16'd3);
    checkOutput("three load", bus.blocks_left_o, 3);
    for (int b = 0; b < 3; b++) begin
      repeat (4999) step();
      pulse_begin();
      repeat (300) step();
      pulse_done();
      checkOutput($sformatf("three blocks after %0d", b), bus.blocks_left_o, 2 - b);
    end
    step();
    checkOutput("three single xfer", xfer_cnt - xs, 1);
    checkOutput("three no terr",     terr_cnt - ts, 0);
    checkOutput("three idle",        bus.busy_o, 0);

    // Read timeout with no start bit: 2^13 cycles.
    xs = xfer_cnt;
    pulse_read(16'd1);
    wait_pulse(9000, lat, gx, gt);
    lat = lat + 1;
    checkOutput("rd timeout err seen", gt, 1);
    checkOutput("rd timeout latency in window", int'(lat >= 8189 && lat <= 8195), 1);
    checkOutput("rd timeout blocks held", bus.blocks_left_o, 1);
    step();
    checkOutput("rd timeout idle after", bus.busy_o, 0);
    checkOutput("rd timeout no xfer",    xfer_cnt - xs, 0);

    // Busy wait released after 3000 cycles.
    bus.timeout_bits_i = 4'd1;
    xs = xfer_cnt; ts = terr_cnt;
    bus.dat0_i = 1'b0;
    pulse_busy();
    repeat (2999) step();
    checkOutput("busy still waiting", bus.busy_o, 1);
    checkOutput("busy no early xfer", xfer_cnt - xs, 0);
    bus.dat0_i = 1'b1;
    step();
    checkOutput("busy xfer after rise", bus.xfer_done_o, 1);
    checkOutput("busy no terr", terr_cnt - ts, 0);
    step();

    // Busy held low: 2^14 cycles.
    bus.dat0_i = 1'b0;
    pulse_busy();
    wait_pulse(17000, lat, gx, gt);
    lat = lat + 1;
    checkOutput("busy timeout err seen", gt, 1);
    checkOutput("busy timeout latency in window", int'(lat >= 16381 && lat <= 16387), 1);
    bus.dat0_i = 1'b1;
    step();
    checkOutput("busy timeout idle after", bus.busy_o, 0);

    // Start bit in the very cycle the timer reaches its limit (cycle 8194 after start).
    bus.timeout_bits_i = 4'd0;
    ts = terr_cnt;
    pulse_read(16'd2);
    repeat (8193) step();
    pulse_begin();
    checkOutput("collide busy", bus.busy_o, 1);
    checkOutput("collide no terr", terr_cnt - ts, 0);
    repeat (9000) step();
    checkOutput("collide no terr in block", terr_cnt - ts, 0);
    pulse_done();
    checkOutput("collide next block", bus.blocks_left_o, 1);
    pulse_abort();
    checkOutput("collide abort idle",   bus.busy_o, 0);
    checkOutput("collide abort blocks", bus.blocks_left_o, 0);

    // Reset while inside a block, then a busy wait right after release.
    xs = xfer_cnt; ts = terr_cnt;
    pulse_read(16'd4);
    repeat (3) step();
    pulse_begin();
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checkOutput("midrst busy",   bus.busy_o,        0);
    checkOutput("midrst blocks", bus.blocks_left_o, 0);
    checkOutput("midrst xfer",   bus.xfer_done_o,   0);
    checkOutput("midrst terr",   bus.timeout_err_o, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.dat0_i = 1'b0;
    pulse_busy();
    checkOutput("postrst busy wait", bus.busy_o, 1);
    wait_pulse(9000, lat, gx, gt);
    lat = lat + 1;
    checkOutput("postrst timer from zero", int'(gt && lat >= 8189 && lat <= 8195), 1);
    checkOutput("postrst no pulses in reset", xfer_cnt - xs, 0);
    bus.dat0_i = 1'b1;
    step();

    // Randomized transactions against a transaction-level model.
    for (int t = 0; t < 14; t++) begin
      int   kind;
      xs = xfer_cnt; ts = terr_cnt;
      kind = $urandom_range(0, 2);
      if (kind < 2) begin
        int   n;
        int   left;
        int   abort_at;
        logic do_abort;
        logic aborted;
        n        = $urandom_range(0, 4);
        left     = (n == 0) ? 1 : n;
        do_abort = ($urandom_range(0, 3) == 0);
        abort_at = $urandom_range(0, left - 1);
        aborted  = 1'b0;
        pulse_read(16'(n));
        checkOutput($sformatf("rnd%0d read load", t), bus.blocks_left_o, left);
        for (int b = 0; b < n || b == 0; b++) begin
          repeat ($urandom_range(1, 300)) step();
          if (do_abort && b == abort_at) begin
            pulse_abort();
            left    = 0;
            aborted = 1'b1;
            checkOutput($sformatf("rnd%0d abort idle", t), bus.busy_o, 0);
            break;
          end
          pulse_begin();
          repeat ($urandom_range(0, 50)) step();
          pulse_done();
          left = left - 1;
          checkOutput($sformatf("rnd%0d blocks b%0d", t, b), bus.blocks_left_o, left);
          checkOutput($sformatf("rnd%0d xfer b%0d", t, b), bus.xfer_done_o, int'(left == 0));
        end
        step();
        checkOutput($sformatf("rnd%0d xfer count", t), xfer_cnt - xs, aborted ? 0 : 1);
        checkOutput($sformatf("rnd%0d blocks end", t), bus.blocks_left_o, 0);
      end else begin
        int d;
        int exp_at;
        int got_at;
        int k;
        d      = $urandom_range(0, 400);
        exp_at = ((d > 2) ? d : 2) + 1;
        got_at = -1;
        bus.dat0_i = (d == 0);
        pulse_busy();
        k = 1;
        while (k < exp_at + 10 && got_at < 0) begin
          if (k == d) bus.dat0_i = 1'b1;
          step();
          k++;
          if (bus.xfer_done_o) got_at = k;
        end
        checkOutput($sformatf("rnd%0d busy release d=%0d", t, d), got_at, exp_at);
        bus.dat0_i = 1'b1;
        step();
      end
      checkOutput($sformatf("rnd%0d no terr", t), terr_cnt - ts, 0);
      checkOutput($sformatf("rnd%0d idle", t), bus.busy_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
